// File: rtl/mandelbrot_pixel_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : mandelbrot_pixel_dispatcher
// Brief    : Raster-order pixel walker that starts one Mandelbrot core per
//            pixel and streams {x, y, iter} results downstream.
//            Optional MANDEL_DISPATCH_STATS_EN adds an in-set pixel counter.
// Revision : 1.0 - initial release
// ============================================================================
module mandelbrot_pixel_dispatcher #(
    parameter int INTEGER_BITS    = 8,
    parameter int FRACTIONAL_BITS = 24,
    parameter int MAX_ITER_WIDTH  = 16,
    parameter int PIX_WIDTH       = 10,
    localparam int DATA_WIDTH     = INTEGER_BITS + FRACTIONAL_BITS
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      frame_start_i,
    input  logic [PIX_WIDTH-1:0]      width_i,
    input  logic [PIX_WIDTH-1:0]      height_i,
    input  logic [DATA_WIDTH-1:0]     x_start_i,
    input  logic [DATA_WIDTH-1:0]     y_start_i,
    input  logic [DATA_WIDTH-1:0]     step_x_i,
    input  logic [DATA_WIDTH-1:0]     step_y_i,
    input  logic [MAX_ITER_WIDTH-1:0] max_iter_i,
    output logic                      core_start_o,
    output logic [DATA_WIDTH-1:0]     core_x0_o,
    output logic [DATA_WIDTH-1:0]     core_y0_o,
    output logic [MAX_ITER_WIDTH-1:0] core_max_iter_o,
    input  logic [MAX_ITER_WIDTH-1:0] core_iter_i,
    input  logic                      core_done_i,
    output logic                      pix_valid_o,
    input  logic                      pix_ready_i,
    output logic [PIX_WIDTH-1:0]      pix_x_o,
    output logic [PIX_WIDTH-1:0]      pix_y_o,
    output logic [MAX_ITER_WIDTH-1:0] pix_iter_o,
    output logic                      pix_last_o,
`ifdef MANDEL_DISPATCH_STATS_EN
    output logic [2*PIX_WIDTH-1:0]    in_set_count_o,
`endif
    output logic                      busy_o,
    output logic                      frame_done_o
);

    localparam logic [PIX_WIDTH-1:0] c_pix_one = PIX_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_OUTPUT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_accept;
    logic                    w_capture;
    logic                    w_xfer;
    logic                    w_row_end;
    logic                    w_last;

    logic [PIX_WIDTH-1:0]    r_width;
    logic [PIX_WIDTH-1:0]    r_height;
    logic [PIX_WIDTH-1:0]    r_px;
    logic [PIX_WIDTH-1:0]    r_py;
    logic [DATA_WIDTH-1:0]   r_x_start;
    logic [DATA_WIDTH-1:0]   r_step_x;
    logic [DATA_WIDTH-1:0]   r_step_y;

    assign w_row_end = (r_px == (r_width - c_pix_one));
    assign w_last    = w_row_end && (r_py == (r_height - c_pix_one));

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_start_i) begin
                    w_accept     = 1'b1;
                    w_state_next = ((width_i == '0) || (height_i == '0)) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT: begin
                // A stale done from the previous pixel was cleared on the start edge.
                if (core_done_i) begin
                    w_capture    = 1'b1;
                    w_state_next = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (pix_ready_i) begin
                    w_xfer       = 1'b1;
                    w_state_next = pix_last_o ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state         <= S_IDLE;
            core_start_o    <= 1'b0;
            pix_valid_o     <= 1'b0;
            busy_o          <= 1'b0;
            frame_done_o    <= 1'b0;
            core_x0_o       <= '0;
            core_y0_o       <= '0;
            core_max_iter_o <= '0;
            pix_x_o         <= '0;
            pix_y_o         <= '0;
            pix_iter_o      <= '0;
            pix_last_o      <= 1'b0;
            r_width         <= '0;
            r_height        <= '0;
            r_px            <= '0;
            r_py            <= '0;
            r_x_start       <= '0;
            r_step_x        <= '0;
            r_step_y        <= '0;
        end else begin
            // Status outputs are registered copies of the next state.
            r_state      <= w_state_next;
            core_start_o <= (w_state_next == S_ISSUE);
            pix_valid_o  <= (w_state_next == S_OUTPUT);
            busy_o       <= (w_state_next != S_IDLE);
            frame_done_o <= (w_state_next == S_DONE);

            if (w_accept) begin
                r_width         <= width_i;
                r_height        <= height_i;
                r_x_start       <= x_start_i;
                r_step_x        <= step_x_i;
                r_step_y        <= step_y_i;
                core_x0_o       <= x_start_i;
                core_y0_o       <= y_start_i;
                core_max_iter_o <= max_iter_i;
                r_px            <= '0;
                r_py            <= '0;
            end

            if (w_capture) begin
                pix_iter_o <= core_iter_i;
                pix_x_o    <= r_px;
                pix_y_o    <= r_py;
                pix_last_o <= w_last;
            end

            // The core coordinate only moves once the current pixel has left.
            if (w_xfer) begin
                pix_last_o <= 1'b0;
                if (!pix_last_o) begin
                    if (!w_row_end) begin
                        r_px      <= r_px + c_pix_one;
                        core_x0_o <= core_x0_o + r_step_x;
                    end else begin
                        r_px      <= '0;
                        core_x0_o <= r_x_start;
                        r_py      <= r_py + c_pix_one;
                        core_y0_o <= core_y0_o + r_step_y;
                    end
                end
            end
        end
    end

`ifdef MANDEL_DISPATCH_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_set_count_o <= '0;
        end else if (w_accept) begin
            in_set_count_o <= '0;
        end else if (w_xfer && (pix_iter_o == core_max_iter_o)) begin
            in_set_count_o <= in_set_count_o + (2*PIX_WIDTH)'(1);
        end
    end
`endif

endmodule
`default_nettype wire
